// File: rtl/mux_n_1_rr_pkg.sv
// Shared definitions for the N-to-1 registered multiplexer.
//   mode_e        : channel selection mode (external select or round-robin)
//   DefaultWidth  : default data bits per channel
//   DefaultN      : default number of input channels
package mux_n_1_rr_pkg;

  typedef enum logic {
    ModeSel = 1'b0,
    ModeRr  = 1'b1
  } mode_e;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultN     = 4;

endpackage

// File: rtl/mux_n_1_rr_if.sv
// Handshake bundle between N producers, the multiplexer and one consumer.
//   mode      : 0 = external select, 1 = round-robin
//   sel       : channel index used in external-select mode
//   in_valid  : per-channel data valid
//   in_ready  : per-channel accept (one-hot or zero)
//   in_data   : channel i at bits [i*WIDTH +: WIDTH]
//   out_valid : output register holds data
//   out_ready : consumer accepts out_data
//   out_data  : registered selected data
//   out_ch    : index of the channel that supplied out_data
// Modports: master drives the request side (producers + consumer), slave is the mux.
interface mux_n_1_rr_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) ();

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter.
//   in_valid_i    : request vector
//   rr_ptr_i      : highest-priority channel for this evaluation (must be < N)
//   grant_o       : index of the first requesting channel at or after rr_ptr_i, wrapping
//   grant_valid_o : at least one channel is requesting
module rr_arbiter_n #(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    in_valid_i,
  input  logic [SELW-1:0] rr_ptr_i,
  output logic [SELW-1:0] grant_o,
  output logic            grant_valid_o
);

  logic [SELW-1:0] idx;

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = SELW'((32'(rr_ptr_i) + off) % N);
      if (!grant_valid_o && in_valid_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o       = idx;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_rr.sv
// N-to-1 datapath multiplexer with a single registered output slot and valid/ready
// handshakes. Channel choice is either an external index or round-robin arbitration.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mux_n_1_rr_if slave modport (selection, N input streams, one output stream)
module mux_n_1_rr
  import mux_n_1_rr_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned N     = DefaultN,
  localparam int unsigned SELW = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  mux_n_1_rr_if.slave   bus
);

  logic            out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

  logic [SELW-1:0] rr_grant;
  logic            rr_grant_valid;
  logic [SELW-1:0] grant;
  logic            grant_valid;
  logic            load_en;
  logic            xfer;
  logic [WIDTH-1:0] grant_data;

  rr_arbiter_n #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .in_valid_i    (bus.in_valid),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (rr_grant),
    .grant_valid_o (rr_grant_valid)
  );

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (bus.mode == ModeRr) begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end else if (32'(bus.sel) < N) begin
      // Out-of-range select quietly grants nothing.
      grant       = bus.sel;
      grant_valid = bus.in_valid[bus.sel];
    end
  end

  // The slot can be refilled when empty or when it drains this cycle.
  assign load_en = !out_valid_q || bus.out_ready;
  assign xfer    = load_en && grant_valid && !rst;

  always_comb begin
    bus.in_ready = '0;
    grant_data   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        bus.in_ready[i] = xfer;
        grant_data      = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
    end
    if (xfer) begin
      out_data_d = grant_data;
      out_ch_d   = grant;
      if (bus.mode == ModeRr) begin
        rr_ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Self-checking bench: a 4-channel instance checked every cycle against a behavioural
// model, directed scenarios with literal expectations, and a 3-channel instance for
// the out-of-range select case.
module tb_mux_n_1_rr;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned N3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_n_1_rr_if #(.WIDTH(W), .N(N))  bus4 ();
  mux_n_1_rr_if #(.WIDTH(W), .N(N3)) bus3 ();

  mux_n_1_rr #(.WIDTH(W), .N(N))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_n_1_rr #(.WIDTH(W), .N(N3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of the 4-channel instance: one output slot plus a priority pointer.
  bit              live = 1'b0;
  logic            m_valid;
  logic [W-1:0]    m_data;
  int unsigned     m_ch, m_ptr;
  logic            n_valid;
  logic [W-1:0]    n_data;
  int unsigned     n_ch, n_ptr;
  logic [N-1:0]    exp_rdy;
  bit              m_ok, m_load;
  int unsigned     m_g, m_c;

  always_comb begin
    m_ok    = 1'b0;
    m_g     = 0;
    m_c     = 0;
    m_load  = !m_valid || bus4.out_ready;
    exp_rdy = '0;
    n_valid = m_valid;
    n_data  = m_data;
    n_ch    = m_ch;
    n_ptr   = m_ptr;
    if (bus4.mode == 1'b0) begin
      if (32'(bus4.sel) < N && bus4.in_valid[bus4.sel]) begin
        m_ok = 1'b1;
        m_g  = 32'(bus4.sel);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        m_c = (m_ptr + 32'(k)) % N;
        if (!m_ok && bus4.in_valid[m_c[1:0]]) begin
          m_ok = 1'b1;
          m_g  = m_c;
        end
      end
    end
    if (rst) begin
      n_valid = 1'b0;
      n_data  = '0;
      n_ch    = 0;
      n_ptr   = 0;
    end else if (m_load) begin
      n_valid = m_ok;
      if (m_ok) begin
        exp_rdy = 4'b0001 << m_g;
        n_data  = bus4.in_data[m_g*W +: W];
        n_ch    = m_g;
        if (bus4.mode == 1'b1) n_ptr = (m_g + 1) % N;
      end
    end
  end

  always @(posedge clk) begin
    live    <= live | rst;
    m_valid <= n_valid;
    m_data  <= n_data;
    m_ch    <= n_ch;
    m_ptr   <= n_ptr;
  end

  always @(negedge clk) begin
    if (live) begin
      check("model in_ready", 64'(bus4.in_ready), 64'(exp_rdy));
      check("model out_valid", 64'(bus4.out_valid), 64'(m_valid));
      check("model out_data", 64'(bus4.out_data), 64'(m_data));
      check("model out_ch", 64'(bus4.out_ch), 64'(m_ch));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus4.mode      = 1'b0;
    bus4.sel       = '0;
    bus4.in_valid  = 4'hF;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b0;
    bus3.mode      = 1'b0;
    bus3.sel       = '0;
    bus3.in_valid  = 3'b111;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b0;

    // Reset with every channel requesting.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(bus4.out_valid), 64'd0);
    check("reset in_ready", 64'(bus4.in_ready), 64'd0);
    check("reset out_data", 64'(bus4.out_data), 64'd0);
    check("reset dut3 out_valid", 64'(bus3.out_valid), 64'd0);

    // External select of channel 2.
    step();
    rst                    = 1'b0;
    bus3.in_valid          = '0;
    bus4.sel               = 2'd2;
    bus4.in_valid          = 4'b0100;
    bus4.in_data[2*W +: W] = 32'hA5A5_0002;
    bus4.out_ready         = 1'b1;
    @(negedge clk);
    check("sel2 in_ready", 64'(bus4.in_ready), 64'b0100);
    step();
    bus4.in_valid = '0;
    @(negedge clk);
    check("sel2 out_valid", 64'(bus4.out_valid), 64'd1);
    check("sel2 out_data", 64'(bus4.out_data), 64'hA5A5_0002);
    check("sel2 out_ch", 64'(bus4.out_ch), 64'd2);

    // Round-robin with all channels requesting: one word per cycle in order 0..3,0..3.
    step();
    bus4.mode     = 1'b1;
    bus4.in_valid = 4'hF;
    for (int i = 0; i < N; i++) bus4.in_data[i*W +: W] = 32'h100 + 32'(i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr in_ready", 64'(bus4.in_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        check("rr out_ch", 64'(bus4.out_ch), 64'((k - 1) % 4));
        check("rr out_valid", 64'(bus4.out_valid), 64'd1);
      end
    end
    step();
    bus4.in_valid = '0;
    @(negedge clk);
    check("rr last out_ch", 64'(bus4.out_ch), 64'd3);

    // Pointer wrap: grant ch2 moves pointer to 3, then {0,2} requesting grants 0, then 2.
    step();
    bus4.in_valid = 4'b0100;
    @(negedge clk);
    check("wrap setup in_ready", 64'(bus4.in_ready), 64'b0100);
    step();
    bus4.in_valid = 4'b0101;
    @(negedge clk);
    check("wrap grant ch0", 64'(bus4.in_ready), 64'b0001);
    step();
    @(negedge clk);
    check("wrap grant ch2", 64'(bus4.in_ready), 64'b0100);

    // Back-pressure holds the slot; release refills in the same cycle.
    step();
    bus4.in_valid  = 4'hF;
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp in_ready", 64'(bus4.in_ready), 64'd0);
      check("bp out_valid", 64'(bus4.out_valid), 64'd1);
      check("bp out_ch", 64'(bus4.out_ch), 64'd2);
      check("bp out_data", 64'(bus4.out_data), 64'h102);
    end
    step();
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 64'(bus4.in_ready), 64'b1000);
    step();
    bus4.in_valid = '0;
    @(negedge clk);
    check("bp refill out_ch", 64'(bus4.out_ch), 64'd3);
    check("bp refill out_data", 64'(bus4.out_data), 64'h103);

    // Out-of-range select on the 3-channel instance: no grant, slot drains.
    step();
    bus3.in_valid           = 3'b111;
    bus3.sel                = 2'd1;
    bus3.out_ready          = 1'b1;
    bus3.in_data[1*W +: W]  = 32'h33;
    step();
    bus3.sel = 2'd3;
    @(negedge clk);
    check("sel3 in_ready", 64'(bus3.in_ready), 64'd0);
    check("sel3 out_valid", 64'(bus3.out_valid), 64'd1);
    check("sel3 out_ch", 64'(bus3.out_ch), 64'd1);
    step();
    @(negedge clk);
    check("sel3 drained", 64'(bus3.out_valid), 64'd0);
    check("sel3 hold ch", 64'(bus3.out_ch), 64'd1);
    check("sel3 hold data", 64'(bus3.out_data), 64'h33);
    check("sel3 in_ready idle", 64'(bus3.in_ready), 64'd0);

    // Randomised traffic on the 4-channel instance, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst            = ($urandom_range(0, 63) == 0);
      bus4.mode      = 1'($urandom_range(0, 1));
      bus4.sel       = 2'($urandom);
      bus4.in_valid  = 4'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) bus4.in_data[i*W +: W] = $urandom;
    end
    step();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
